bram_input_1x1_ctrl: RTL

Sequencer for the 1x1-convolution input feature-map buffer. It fills the buffer from an upstream pixel stream (one pixel = all channels per beat), then replays the full map NUM_PASSES times to the 1x1 conv PE array, once per output-channel group. The downstream side uses valid/ready and has a 2-entry output skid, so either buffer read latency streams at one pixel per cycle.

---
 rtl/bram_input_1x1_ctrl_pkg.sv | 35 +++
 rtl/bram_input_1x1_skid.sv | 70 +++++++
 rtl/bram_input_1x1_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/bram_input_1x1_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_input_1x1_ctrl_pkg
// Description : Definitions shared by the 1x1-convolution input path:
//               sequencer state encoding, legal buffer read latencies,
//               output skid depth and pixel/address width helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bram_input_1x1_ctrl_pkg;

  // Sequencer states
  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  // Legal buffer read latencies
  localparam int RDLAT_COMB = 0;
  localparam int RDLAT_REG  = 1;

  // Entries in the downstream skid; also the read credit limit
  localparam int SKID_DEPTH = 2;

  // Width of one packed pixel beat
  function automatic int calc_pw(input int data_width, input int channels);
    return data_width * channels;
  endfunction

  // Pixel address width; never collapses to zero for tiny maps
  function automatic int calc_aw(input int pixels);
    return (pixels < 2) ? 1 : $clog2(pixels);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_input_1x1_skid.sv
`default_nettype none
// ============================================================================
// Module      : bram_input_1x1_skid
// Description : Two-entry FIFO holding returned buffer reads together with
//               their {last, last_pixel} tags. The head is presented
//               combinationally. Push and pop in the same cycle are allowed
//               even when full (occupancy unchanged).
// Ports       : clk, rst_n   - clock, async active-low reset
//               i_push/i_data - write side
//               i_pop         - remove head (ignored when empty)
//               o_data        - current head
//               o_count       - occupancy 0..2
//               o_empty       - no entry held
// Revision    : 1.0 - initial release
// ============================================================================
module bram_input_1x1_skid #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  // When full, the slot being written is the head that is leaving this cycle
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0   <= '0;
      r_mem1   <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        if (r_wr_ptr) begin
          r_mem1 <= i_data;
        end else begin
          r_mem0 <= i_data;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

  assign o_data  = r_rd_ptr ? r_mem1 : r_mem0;
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/bram_input_1x1_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_input_1x1_ctrl
// Description : Input feature-map buffer sequencer for the 1x1 conv PE array.
//               FILL   : accept PIXELS upstream beats, write them to the buffer
//               STREAM : replay the map NUM_PASSES times through a read pipe
//                        (0 or 1 cycle latency) into a 2-entry output skid
//               DRAIN  : wait for the final beat to be accepted downstream
// Ports       : clk, rst_n                      - clock, async active-low reset
//               i_in_valid/o_in_ready/i_in_data - upstream pixel stream
//               o_buf_wr_*                      - buffer write port
//               o_buf_rd_en/o_buf_rd_addr       - buffer read request
//               i_buf_rd_data                   - buffer read data
//               o_out_valid/i_out_ready/o_out_* - pixel stream to PE array
//               o_frame_done                    - pulse with final beat accept
// Revision    : 1.0 - initial release
// ============================================================================
module bram_input_1x1_ctrl
  import bram_input_1x1_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IN_CHANNELS = 3,
  parameter int IN_WIDTH    = 5,
  parameter int IN_HEIGHT   = 5,
  parameter int NUM_PASSES  = 2,
  parameter int RD_LATENCY  = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  // upstream
  input  logic                                  i_in_valid,
  output logic                                  o_in_ready,
  input  logic [DATA_WIDTH*IN_CHANNELS-1:0]     i_in_data,
  // buffer write
  output logic                                  o_buf_wr_en,
  output logic [calc_aw(IN_WIDTH*IN_HEIGHT)-1:0] o_buf_wr_addr,
  output logic [DATA_WIDTH*IN_CHANNELS-1:0]     o_buf_wr_data,
  // buffer read
  output logic                                  o_buf_rd_en,
  output logic [calc_aw(IN_WIDTH*IN_HEIGHT)-1:0] o_buf_rd_addr,
  input  logic [DATA_WIDTH*IN_CHANNELS-1:0]     i_buf_rd_data,
  // downstream
  output logic                                  o_out_valid,
  input  logic                                  i_out_ready,
  output logic [DATA_WIDTH*IN_CHANNELS-1:0]     o_out_data,
  output logic                                  o_out_last_pixel,
  output logic                                  o_out_last,
  output logic                                  o_frame_done
);

  localparam int PIXELS = IN_WIDTH * IN_HEIGHT;
  localparam int AW     = calc_aw(PIXELS);
  localparam int PW     = calc_pw(DATA_WIDTH, IN_CHANNELS);
  localparam int FW     = PW + 2;
  localparam int PCW    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  localparam logic [AW-1:0]  LAST_ADDR = AW'(PIXELS - 1);
  localparam logic [PCW-1:0] LAST_PASS = PCW'(NUM_PASSES - 1);

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  logic [1:0]     r_state;
  logic [AW-1:0]  r_wr_cnt;
  logic [AW-1:0]  r_rd_cnt;
  logic [PCW-1:0] r_pass_cnt;
  // Holds in_ready low until the first clock edge after reset release
  logic           r_active;

  logic           w_in_hs;
  logic           w_issue;
  logic           w_rd_last_pixel;
  logic           w_rd_last;
  logic           w_pop;
  logic           w_frame_done;
  logic [2:0]     w_occupancy;

  // Latency pipe to skid
  logic           w_push;
  logic [FW-1:0]  w_push_data;
  logic           w_inflight;

  // Skid
  logic [FW-1:0]  w_head;
  logic [1:0]     w_count;
  logic           w_empty;
  logic           w_head_last;

  // --------------------------------------------------------------------------
  // Fill side
  // --------------------------------------------------------------------------
  assign o_in_ready = (r_state == ST_FILL) && r_active;
  assign w_in_hs    = o_in_ready && i_in_valid;

  assign o_buf_wr_en   = w_in_hs;
  assign o_buf_wr_addr = w_in_hs ? r_wr_cnt  : '0;
  assign o_buf_wr_data = w_in_hs ? i_in_data : '0;

  // --------------------------------------------------------------------------
  // Read issue: a slot is freed by a pop in the same cycle, so the credit is
  // occupancy after this cycle's pop plus reads still travelling the pipe.
  // --------------------------------------------------------------------------
  assign w_pop       = o_out_valid && i_out_ready;
  assign w_occupancy = {1'b0, w_count} + {2'b0, w_inflight} - {2'b0, w_pop};
  assign w_issue     = (r_state == ST_STREAM) && (w_occupancy < 3'(SKID_DEPTH));

  assign w_rd_last_pixel = (r_rd_cnt == LAST_ADDR);
  assign w_rd_last       = w_rd_last_pixel && (r_pass_cnt == LAST_PASS);

  assign o_buf_rd_en   = w_issue;
  assign o_buf_rd_addr = w_issue ? r_rd_cnt : '0;

  // --------------------------------------------------------------------------
  // Read latency pipe: carries the issue valid and its tags alongside the
  // buffer access so that returned data is pushed with the right tags.
  // --------------------------------------------------------------------------
  generate
    if (RD_LATENCY == RDLAT_COMB) begin : g_lat_comb
      assign w_push      = w_issue;
      assign w_push_data = {w_rd_last, w_rd_last_pixel, i_buf_rd_data};
      assign w_inflight  = 1'b0;
    end else begin : g_lat_reg
      logic r_pipe_vld;
      logic r_pipe_last;
      logic r_pipe_last_pixel;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe_vld        <= 1'b0;
          r_pipe_last       <= 1'b0;
          r_pipe_last_pixel <= 1'b0;
        end else begin
          r_pipe_vld        <= w_issue;
          r_pipe_last       <= w_issue && w_rd_last;
          r_pipe_last_pixel <= w_issue && w_rd_last_pixel;
        end
      end

      assign w_push      = r_pipe_vld;
      assign w_push_data = {r_pipe_last, r_pipe_last_pixel, i_buf_rd_data};
      assign w_inflight  = r_pipe_vld;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output skid
  // --------------------------------------------------------------------------
  bram_input_1x1_skid #(
    .WIDTH (FW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign w_head_last      = w_head[PW+1];
  assign o_out_valid      = !w_empty;
  assign o_out_data       = w_head[PW-1:0];
  assign o_out_last_pixel = !w_empty && w_head[PW];
  assign o_out_last       = !w_empty && w_head_last;

  // Frame completes in the same cycle the final beat is accepted
  assign w_frame_done = (r_state == ST_DRAIN) && w_pop && w_head_last;
  assign o_frame_done = w_frame_done;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_pass_cnt <= '0;
      r_active   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      case (r_state)
        ST_FILL: begin
          if (w_in_hs) begin
            if (r_wr_cnt == LAST_ADDR) begin
              r_wr_cnt <= '0;
              r_state  <= ST_STREAM;
            end else begin
              r_wr_cnt <= r_wr_cnt + AW'(1);
            end
          end
        end
        ST_STREAM: begin
          if (w_issue) begin
            if (w_rd_last_pixel) begin
              r_rd_cnt <= '0;
              if (r_pass_cnt == LAST_PASS) begin
                r_pass_cnt <= '0;
                r_state    <= ST_DRAIN;
              end else begin
                r_pass_cnt <= r_pass_cnt + PCW'(1);
              end
            end else begin
              r_rd_cnt <= r_rd_cnt + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_frame_done) begin
            r_state    <= ST_FILL;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_pass_cnt <= '0;
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
